// File: rtl/alarm_ring_if.sv
// Signal bundle between the time/alarm-setting logic and the alarm ring controller.
// The master drives time, alarm setting and user requests; the slave returns buzzer/state flags.
interface alarm_ring_if;
  logic [5:0] i_sec;
  logic [5:0] i_min;
  logic [5:0] i_alarm_sec;
  logic [5:0] i_alarm_min;
  logic       i_alarm_en;
  logic       i_stop;
  logic       i_snooze;
  logic       o_buzz;
  logic       o_ringing;
  logic       o_snoozing;

  modport master (
    output i_sec,
    output i_min,
    output i_alarm_sec,
    output i_alarm_min,
    output i_alarm_en,
    output i_stop,
    output i_snooze,
    input  o_buzz,
    input  o_ringing,
    input  o_snoozing
  );

  modport slave (
    input  i_sec,
    input  i_min,
    input  i_alarm_sec,
    input  i_alarm_min,
    input  i_alarm_en,
    input  i_stop,
    input  i_snooze,
    output o_buzz,
    output o_ringing,
    output o_snoozing
  );
endinterface

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring controller: detects the time stepping onto the alarm value, rings with a
// 1 s on / 1 s off tone cadence, supports snooze, stop and auto-stop after RING_SEC seconds.
module alarm_ring_ctrl #(
  parameter int unsigned TONE_HALF  = 25000,
  parameter int unsigned RING_SEC   = 30,
  parameter int unsigned SNOOZE_SEC = 60
) (
  input logic         clk,
  input logic         rst_n,
  alarm_ring_if.slave bus
);

  localparam int unsigned ToneW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam logic [ToneW-1:0] ToneLast   = ToneW'(TONE_HALF - 1);
  localparam logic [7:0]       RingLast   = 8'(RING_SEC - 1);
  localparam logic [7:0]       SnoozeLast = 8'(SNOOZE_SEC - 1);

  typedef enum logic [1:0] {StIdle, StRing, StSnooze} state_e;

  state_e           state_q, state_d;
  logic [7:0]       sec_cnt_q, sec_cnt_d;
  logic [11:0]      t_q;
  logic             t_vld_q;
  logic [ToneW-1:0] tone_cnt_q, tone_cnt_d;
  logic             tone_q, tone_d;
  logic             buzz_q, ringing_q, snoozing_q;

  logic [11:0] t_now;
  logic        alarm_valid;
  logic        tick;
  logic        match;
  logic        kill;

  assign t_now       = {bus.i_min, bus.i_sec};
  assign alarm_valid = (bus.i_alarm_min <= 6'd59) && (bus.i_alarm_sec <= 6'd59);
  // t_vld_q masks the first cycle after reset, when t_q still holds its reset value.
  assign tick        = (t_now != t_q) && t_vld_q;
  assign match       = tick && bus.i_alarm_en && alarm_valid &&
                       (t_now == {bus.i_alarm_min, bus.i_alarm_sec});
  assign kill        = bus.i_stop || !bus.i_alarm_en;

  always_comb begin
    state_d   = state_q;
    sec_cnt_d = sec_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (match) begin
          state_d   = StRing;
          sec_cnt_d = 8'd0;
        end
      end
      StRing: begin
        if (kill) begin
          state_d   = StIdle;
          sec_cnt_d = 8'd0;
        end else if (bus.i_snooze) begin
          state_d   = StSnooze;
          sec_cnt_d = 8'd0;
        end else if (tick && (sec_cnt_q == RingLast)) begin
          state_d   = StIdle;
          sec_cnt_d = 8'd0;
        end else if (tick) begin
          sec_cnt_d = sec_cnt_q + 8'd1;
        end
      end
      StSnooze: begin
        if (kill) begin
          state_d   = StIdle;
          sec_cnt_d = 8'd0;
        end else if (tick && (sec_cnt_q == SnoozeLast)) begin
          state_d   = StRing;
          sec_cnt_d = 8'd0;
        end else if (tick) begin
          sec_cnt_d = sec_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = StIdle;
        sec_cnt_d = 8'd0;
      end
    endcase
  end

  // Tone generator only runs while staying in RING; entering RING restarts it from zero.
  always_comb begin
    tone_cnt_d = '0;
    tone_d     = 1'b0;
    if ((state_q == StRing) && (state_d == StRing)) begin
      if (tone_cnt_q == ToneLast) begin
        tone_cnt_d = '0;
        tone_d     = ~tone_q;
      end else begin
        tone_cnt_d = tone_cnt_q + ToneW'(1);
        tone_d     = tone_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sec_cnt_q  <= 8'd0;
      t_q        <= 12'd0;
      t_vld_q    <= 1'b0;
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
      buzz_q     <= 1'b0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_cnt_q  <= sec_cnt_d;
      t_q        <= t_now;
      t_vld_q    <= 1'b1;
      tone_cnt_q <= tone_cnt_d;
      tone_q     <= tone_d;
      // Outputs use next-state values so they line up with the state they describe.
      buzz_q     <= tone_d && (state_d == StRing) && !sec_cnt_d[0];
      ringing_q  <= (state_d == StRing);
      snoozing_q <= (state_d == StSnooze);
    end
  end

  assign bus.o_buzz     = buzz_q;
  assign bus.o_ringing  = ringing_q;
  assign bus.o_snoozing = snoozing_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed bench for alarm_ring_ctrl: a vector table for ring/snooze/stop flows plus
// hand-written sequences for time wrap, invalid alarm, reset release and async reset.
module tb_alarm_ring_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  alarm_ring_if bus ();

  alarm_ring_ctrl #(
    .TONE_HALF (4),
    .RING_SEC  (3),
    .SNOOZE_SEC(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] min;
    logic [5:0] sec;
    logic       en;
    logic       stop;
    logic       snz;
    logic [2:0] exp;  // {buzz, ringing, snoozing}
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [2:0] outs();
    return {bus.o_buzz, bus.o_ringing, bus.o_snoozing};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0b%b) expected %0d (0b%b)", name, act, act[2:0], exp, exp[2:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int m, input int s, input logic en, input logic stop,
                     input logic snz, input logic [2:0] exp, input string name);
    vec_t v;
    v.min  = 6'(m);
    v.sec  = 6'(s);
    v.en   = en;
    v.stop = stop;
    v.snz  = snz;
    v.exp  = exp;
    v.name = name;
    vecs.push_back(v);
  endtask

  task automatic set_time(input int m, input int s);
    bus.i_min = 6'(m);
    bus.i_sec = 6'(s);
  endtask

  initial begin
    int bad;
    rst_n           = 1'b0;
    set_time(1, 4);
    bus.i_alarm_min = 6'd1;
    bus.i_alarm_sec = 6'd5;
    bus.i_alarm_en  = 1'b1;
    bus.i_stop      = 1'b0;
    bus.i_snooze    = 1'b0;
    repeat (3) step();
    check("reset_outputs", int'(outs()), 0);
    rst_n = 1'b1;

    // Ring, tone cadence, auto-stop after three ticks.
    add(1, 4, 1, 0, 0, 3'b000, "first_cycle_idle");
    add(1, 5, 1, 0, 0, 3'b010, "match_ring");
    add(1, 5, 1, 0, 0, 3'b010, "tone_c1");
    add(1, 5, 1, 0, 0, 3'b010, "tone_c2");
    add(1, 5, 1, 0, 0, 3'b010, "tone_c3");
    add(1, 5, 1, 0, 0, 3'b110, "tone_high");
    add(1, 5, 1, 0, 0, 3'b110, "tone_high1");
    add(1, 5, 1, 0, 0, 3'b110, "tone_high2");
    add(1, 5, 1, 0, 0, 3'b110, "tone_high3");
    add(1, 5, 1, 0, 0, 3'b010, "tone_low");
    add(1, 6, 1, 0, 0, 3'b010, "sec1_tick");
    add(1, 6, 1, 0, 0, 3'b010, "sec1_c2");
    add(1, 6, 1, 0, 0, 3'b010, "sec1_c3");
    add(1, 6, 1, 0, 0, 3'b010, "sec1_muted");
    add(1, 7, 1, 0, 0, 3'b110, "sec2_audible");
    add(1, 8, 1, 0, 0, 3'b000, "auto_stop");
    // Snooze then re-ring after two ticks; stop+snooze together.
    add(1, 4, 1, 0, 0, 3'b000, "rearm_idle");
    add(1, 5, 1, 0, 0, 3'b010, "ring2");
    add(1, 5, 1, 0, 1, 3'b001, "snooze");
    add(1, 6, 1, 0, 0, 3'b001, "snooze_tick1");
    add(1, 7, 1, 0, 0, 3'b010, "re_ring");
    add(1, 7, 1, 0, 0, 3'b010, "re_ring_c1");
    add(1, 7, 1, 0, 0, 3'b010, "re_ring_c2");
    add(1, 7, 1, 0, 0, 3'b010, "re_ring_c3");
    add(1, 7, 1, 0, 0, 3'b110, "re_ring_audible");
    add(1, 7, 1, 1, 1, 3'b000, "stop_and_snooze");
    // Disable during snooze; snooze ignored while snoozing.
    add(1, 4, 1, 0, 0, 3'b000, "idle3");
    add(1, 5, 1, 0, 0, 3'b010, "ring3");
    add(1, 5, 1, 0, 1, 3'b001, "snooze3");
    add(1, 5, 0, 0, 0, 3'b000, "disable_in_snooze");
    add(1, 4, 1, 0, 0, 3'b000, "idle4");
    add(1, 5, 1, 0, 0, 3'b010, "ring4");
    add(1, 5, 1, 0, 1, 3'b001, "snooze4");
    add(1, 5, 1, 0, 1, 3'b001, "snooze_ignored");
    add(1, 5, 1, 1, 0, 3'b000, "stop_in_snooze");
    add(1, 5, 1, 0, 0, 3'b000, "stays_idle");

    foreach (vecs[i]) begin
      set_time(int'(vecs[i].min), int'(vecs[i].sec));
      bus.i_alarm_en = vecs[i].en;
      bus.i_stop     = vecs[i].stop;
      bus.i_snooze   = vecs[i].snz;
      step();
      check(vecs[i].name, int'(outs()), int'(vecs[i].exp));
    end
    bus.i_stop   = 1'b0;
    bus.i_snooze = 1'b0;

    // Alarm 00:00 rings on the 59:59 -> 00:00 wrap.
    bus.i_alarm_min = 6'd0;
    bus.i_alarm_sec = 6'd0;
    set_time(59, 59);
    step();
    check("pre_wrap_idle", int'(outs()), 0);
    set_time(0, 0);
    step();
    check("wrap_ring", int'(outs()), 3'b010);
    bus.i_stop = 1'b1;
    step();
    bus.i_stop = 1'b0;
    check("wrap_stop", int'(outs()), 0);

    // Alarm 00:60 is out of range and must never ring over a full hour.
    bus.i_alarm_sec = 6'd60;
    bad = 0;
    for (int m = 0; m < 60; m++) begin
      for (int s = 0; s < 60; s++) begin
        set_time(m, s);
        step();
        if (bus.o_ringing || bus.o_snoozing) bad++;
      end
    end
    check("invalid_alarm_cycles", bad, 0);

    // Reset released with T already equal to the alarm: no tick, stays idle.
    rst_n           = 1'b0;
    bus.i_alarm_min = 6'd1;
    bus.i_alarm_sec = 6'd5;
    set_time(1, 5);
    repeat (2) step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("release_hold_idle%0d", k), int'(outs()), 0);
    end

    // Asynchronous reset in the middle of an audible ring.
    set_time(1, 4);
    step();
    set_time(1, 5);
    step();
    check("pre_reset_ring", int'(outs()), 3'b010);
    repeat (4) step();
    check("pre_reset_buzz", int'(outs()), 3'b110);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", int'(outs()), 0);
    step();
    check("reset_held_outputs", int'(outs()), 0);
    rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarm_ring_ctrl.md
ALARM_RING_CTRL -- requirements
Module: alarm_ring_ctrl

Parameters
REQ-001 SHALL have parameter TONE_HALF, default 25000, clk cycles per buzzer half-period (1 kHz tone at 50 MHz).
REQ-002 SHALL have parameter RING_SEC, default 30, seconds of ringing before auto-stop (range 1..255).
REQ-003 SHALL have parameter SNOOZE_SEC, default 60, seconds of silence before re-ring (range 1..255).

Interface
REQ-004 SHALL have clk  in  1  system clock (50 MHz); the only clock.
REQ-005 SHALL have rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have i_sec  in  6  current seconds 0..59, level, from the min/sec counter.
REQ-007 SHALL have i_min  in  6  current minutes 0..59, level.
REQ-008 SHALL have i_alarm_sec  in  6  alarm seconds setting; values >59 never match.
REQ-009 SHALL have i_alarm_min  in  6  alarm minutes setting; values >59 never match.
REQ-010 SHALL have i_alarm_en  in  1  alarm armed, level.
REQ-011 SHALL have i_stop  in  1  stop request, single-cycle pulse, synchronous to clk (debounced upstream).
REQ-012 SHALL have i_snooze  in  1  snooze request, single-cycle pulse, synchronous to clk.
REQ-013 SHALL have o_buzz  out  1  buzzer drive, registered.
REQ-014 SHALL have o_ringing  out  1  high while state RING, registered.
REQ-015 SHALL have o_snoozing  out  1  high while state SNOOZE, registered.

Function
REQ-016 SHALL register T={i_min,i_sec} into t_q every cycle; tick = (T != t_q) AND t_vld; t_vld goes 1 on the first cycle after reset and stays 1 (suppresses spurious tick after reset).
REQ-017 SHALL define match = tick AND i_alarm_en AND T=={i_alarm_min,i_alarm_sec}.
REQ-018 SHALL implement FSM IDLE/RING/SNOOZE with 8-bit second counter sec_cnt.
REQ-019 IDLE: match -> RING, sec_cnt=0; otherwise stay.
REQ-020 RING: stop or !i_alarm_en -> IDLE; else snooze -> SNOOZE, sec_cnt=0; else tick with sec_cnt==RING_SEC-1 -> IDLE; else tick -> sec_cnt+1.
REQ-021 SNOOZE: stop or !i_alarm_en -> IDLE; else tick with sec_cnt==SNOOZE_SEC-1 -> RING, sec_cnt=0; else tick -> sec_cnt+1; i_snooze ignored.
REQ-022 Priority per cycle SHALL be: stop/disable > snooze > tick/timeout > match; i_stop and i_snooze together -> IDLE.
REQ-023 A match occurring while in RING or SNOOZE SHALL be ignored (no restart of sec_cnt).
REQ-024 o_ringing/o_snoozing SHALL assert on the clk edge that changes state: o_ringing rises 1 cycle after T changes to the alarm value.
REQ-025 Tone: counter 0..TONE_HALF-1 and tone_q toggle at wrap, running only in RING; both held at 0 outside RING and cleared on RING entry.
REQ-026 o_buzz SHALL be tone_q AND (state==RING) AND NOT sec_cnt[0] (1 s on / 1 s off cadence, first second audible), registered.
REQ-027 Time wrap 59:59->00:00 SHALL count as a tick like any other change; alarm 00:00 SHALL match on that wrap.
REQ-028 Manual time setting upstream SHALL be treated identically: any change of T is a tick (stepping onto the alarm value rings).

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, sec_cnt=0, t_q=0, t_vld=0, tone counter=0, tone_q=0, o_buzz=0, o_ringing=0, o_snoozing=0, including mid-RING/SNOOZE.
REQ-030 After release, no tick/match SHALL occur in the first clk cycle regardless of T.

Verification (TONE_HALF=4, RING_SEC=3, SNOOZE_SEC=2)
REQ-031 Alarm 01:05, en=1, T steps 01:04->01:05 -> o_ringing=1 next cycle; o_buzz toggles every 4 cycles during sec_cnt=0, low during sec_cnt=1; after 3 ticks back to IDLE, o_buzz=0.
REQ-032 Ringing, i_snooze pulse -> o_snoozing=1, o_buzz=0; 2 ticks later -> o_ringing=1, sec_cnt=0.
REQ-033 Ringing, i_stop and i_snooze same cycle -> IDLE; i_alarm_en dropped in SNOOZE -> IDLE next cycle.
REQ-034 Alarm 00:00, T 59:59->00:00 -> RING; alarm 00:60 -> never rings over a full hour sweep.
REQ-035 Release reset with T=01:05 equal to alarm, held constant -> stays IDLE; rst_n low mid-RING -> all outputs 0 immediately.
